// File: rtl/multi_adc_square_pkg.sv
// rtl/multi_adc_square_pkg.sv - shared types and constants for multi_adc_square
// Contents: FSM state enum, mode encodings, sum-width helper.
package multi_adc_square_pkg;

  typedef enum logic [2:0] {
    S_SOC  = 3'd0,
    S_EOC  = 3'd1,
    S_CALC = 3'd2,
    S_OUT  = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  localparam logic MODE_SQ_SUM = 1'b0;  // (sum of x_i)^2
  localparam logic MODE_SUM_SQ = 1'b1;  // sum of x_i^2

  // Width holding the sum of n_ch unsigned w-bit samples; a single
  // channel still gets one guard bit so the datapath shape is uniform.
  function automatic int sum_width(input int n_ch, input int w);
    return w + ((n_ch > 1) ? $clog2(n_ch) : 1);
  endfunction

endpackage

// File: rtl/seq_squarer.sv
// rtl/seq_squarer.sv - sequential shift-add squarer, SW+1 cycles per job
// Ports:
//   clock, reset : clock, synchronous active-high reset (discards any job)
//   start, a     : job request and SW-bit operand, accepted when not busy
//   busy         : high during the SW shift-add cycles
//   done         : one-cycle pulse; p holds a*a from then until the next start
//   p            : 2*SW-bit product
module seq_squarer #(
  parameter int SW = 9
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [SW-1:0]   a,
  output logic            busy,
  output logic            done,
  output logic [2*SW-1:0] p
);

  localparam int PW  = 2 * SW;
  localparam int CNW = $clog2(SW + 1);

  logic [PW-1:0]  mcand;
  logic [SW-1:0]  mplier;
  logic [CNW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        // Load cycle: operand is both multiplicand and multiplier.
        busy   <= 1'b1;
        mcand  <= PW'(a);
        mplier <= a;
        p      <= '0;
        cnt    <= CNW'(SW);
      end else if (busy) begin
        if (mplier[0]) begin
          p <= p + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNW'(1);
        if (cnt == CNW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_adc_square.sv
// rtl/multi_adc_square.sv - N-channel ADC collector computing (sum x)^2 or sum(x^2)
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   soc          : shared start-of-conversion to all converters
//   eoc[N_CH]    : per-channel end-of-conversion
//   x[N_CH*W]    : packed samples, channel i at [i*W +: W]
//   mode         : MODE_SQ_SUM / MODE_SUM_SQ, latched with the samples
//   q[QW]        : result, updated only on entry to S_OUT
//   dav_         : data valid, active low
//   rfd          : consumer ready-for-data (level sensitive)
module multi_adc_square
  import multi_adc_square_pkg::*;
#(
  parameter int   N_CH = 2,
  parameter int   W    = 8,
  localparam int  SW   = sum_width(N_CH, W),
  localparam int  QW   = 2 * SW
) (
  input  logic            clock,
  input  logic            reset,
  output logic            soc,
  input  logic [N_CH-1:0] eoc,
  input  logic [N_CH*W-1:0] x,
  input  logic            mode,
  output logic [QW-1:0]   q,
  output logic            dav_,
  input  logic            rfd
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t          state;
  logic [N_CH*W-1:0] x_r;
  logic            mode_r;
  logic [QW-1:0]   acc;
  logic [CW-1:0]   ch_idx;      // channel whose job is in flight
  logic            calc_first;  // first cycle of S_CALC: launch job 0

  logic [SW-1:0]   sum;
  logic [CW-1:0]   next_idx;
  logic            job_last;
  logic            sq_start;
  logic [SW-1:0]   sq_a;
  logic            sq_busy;
  logic            sq_done;
  logic [QW-1:0]   sq_p;
  logic [QW-1:0]   acc_next;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + SW'(x_r[i*W +: W]);
    end
  end

  // The next job is launched in the same cycle the previous one reports
  // done, so jobs run back to back with no idle cycle between them.
  always_comb begin
    next_idx = calc_first ? '0 : (ch_idx + CW'(1));
    job_last = (mode_r == MODE_SQ_SUM) || (ch_idx == CW'(N_CH - 1));
    sq_start = (state == S_CALC) && !sq_busy &&
               (calc_first || (sq_done && !job_last));
    sq_a     = (mode_r == MODE_SQ_SUM) ? sum
                                       : SW'(x_r[int'(next_idx)*W +: W]);
    acc_next = acc + sq_p;
  end

  seq_squarer #(.SW(SW)) u_squarer (
    .clock (clock),
    .reset (reset),
    .start (sq_start),
    .a     (sq_a),
    .busy  (sq_busy),
    .done  (sq_done),
    .p     (sq_p)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_SOC;
      soc        <= 1'b0;
      dav_       <= 1'b1;
      q          <= '0;
      x_r        <= '0;
      mode_r     <= MODE_SQ_SUM;
      acc        <= '0;
      ch_idx     <= '0;
      calc_first <= 1'b0;
    end else begin
      unique case (state)
        S_SOC: begin
          if (&(~eoc)) begin
            soc   <= 1'b0;
            state <= S_EOC;
          end else begin
            soc <= 1'b1;
          end
        end
        S_EOC: begin
          // Skewed converters: wait for every channel before sampling.
          if (&eoc) begin
            x_r        <= x;
            mode_r     <= mode;
            acc        <= '0;
            ch_idx     <= '0;
            calc_first <= 1'b1;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          calc_first <= 1'b0;
          if (sq_done) begin
            if (job_last) begin
              q     <= (mode_r == MODE_SQ_SUM) ? sq_p : acc_next;
              dav_  <= 1'b0;
              state <= S_OUT;
            end else begin
              acc    <= acc_next;
              ch_idx <= ch_idx + CW'(1);
            end
          end
        end
        S_OUT: begin
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          if (rfd) begin
            soc   <= 1'b1;
            state <= S_SOC;
          end
        end
        default: begin
          state <= S_SOC;
          soc   <= 1'b0;
          dav_  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_adc_square.sv
// tb/tb_multi_adc_square.sv - self-checking bench for multi_adc_square
module tb_multi_adc_square;

  logic        clock = 1'b0;
  logic        reset;

  logic        soc;
  logic [1:0]  eoc;
  logic [15:0] x;
  logic        mode;
  logic [17:0] q;
  logic        dav_;
  logic        rfd;

  logic        soc4;
  logic [3:0]  eoc4;
  logic [47:0] x4;
  logic        mode4;
  logic [27:0] q4;
  logic        dav4_;
  logic        rfd4;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  multi_adc_square dut (
    .clock (clock), .reset (reset), .soc (soc), .eoc (eoc), .x (x),
    .mode (mode), .q (q), .dav_ (dav_), .rfd (rfd)
  );

  multi_adc_square #(.N_CH(4), .W(12)) dut4 (
    .clock (clock), .reset (reset), .soc (soc4), .eoc (eoc4), .x (x4),
    .mode (mode4), .q (q4), .dav_ (dav4_), .rfd (rfd4)
  );

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic run2(input logic [7:0] a0, input logic [7:0] a1, input logic m,
                      input int lat_exp, input int stall, input string name);
    int          cnt;
    bit          ok;
    logic [31:0] e;
    logic [31:0] got_q;
    logic [17:0] hold_q;

    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (soc === 1'b1) begin ok = 1; break; end
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s soc_rise got=%b exp=1", name, soc);
    end

    eoc = 2'b00;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (soc === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s soc_fall got=%b exp=0", name, soc);
    end

    repeat (3) @(negedge clock);
    x    = {a1, a0};
    mode = m;
    if (m == 1'b0) e = (32'(a0) + 32'(a1)) * (32'(a0) + 32'(a1));
    else           e = 32'(a0) * 32'(a0) + 32'(a1) * 32'(a1);
    exp_q.push_back(e);
    eoc = 2'b11;

    cnt = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cnt++;
      x    = 16'($urandom);
      mode = ~m;
      if (dav_ === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || (cnt - 1) != lat_exp) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, cnt - 1, lat_exp);
    end

    got_q = 32'(q);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty got=%0d exp=entry", name, got_q);
    end else begin
      e = exp_q.pop_front();
      if (got_q !== e) begin
        errors++;
        $display("FAIL %s q got=%0d exp=%0d", name, got_q, e);
      end
    end

    if (stall > 0) begin
      hold_q = q;
      ok = 1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        if (q !== hold_q || dav_ !== 1'b0 || soc !== 1'b0) ok = 0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s stall q=%0d exp=%0d dav_=%b soc=%b exp dav_=0 soc=0",
                 name, q, hold_q, dav_, soc);
      end
    end

    rfd = 1'b0;
    @(negedge clock);
    checks++;
    if (dav_ !== 1'b1) begin
      errors++;
      $display("FAIL %s dav_rise got=%b exp=1", name, dav_);
    end
    checks++;
    if (soc !== 1'b0) begin
      errors++;
      $display("FAIL %s soc_in_ack got=%b exp=0", name, soc);
    end
    rfd = 1'b1;
    @(negedge clock);
    checks++;
    if (soc !== 1'b1) begin
      errors++;
      $display("FAIL %s soc_restart got=%b exp=1", name, soc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    eoc = 2'b11; x = '0; mode = 1'b0; rfd = 1'b1;
    eoc4 = 4'hF; x4 = '0; mode4 = 1'b0; rfd4 = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (soc !== 1'b0) begin
      errors++;
      $display("FAIL reset_soc got=%b exp=0", soc);
    end
    checks++;
    if (dav_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_dav got=%b exp=1", dav_);
    end
    checks++;
    if (q !== 18'd0) begin
      errors++;
      $display("FAIL reset_q got=%0d exp=0", q);
    end
    checks++;
    if (q4 !== 28'd0 || dav4_ !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut4 q=%0d dav_=%b exp q=0 dav_=1", q4, dav4_);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (soc !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_soc got=%b exp=1", soc);
    end
  endtask

  task automatic test_mode0();
    run2(8'hFF, 8'hFF, 1'b0, 11, 0, "m0_ff");
    run2(8'd1,  8'd4,  1'b0, 11, 0, "m0_1_4");
  endtask

  task automatic test_mode1();
    run2(8'd3,  8'd4,  1'b1, 21, 0, "m1_3_4");
    run2(8'hFF, 8'hFF, 1'b1, 21, 0, "m1_ff");
  endtask

  task automatic test_back_to_back();
    logic m;
    for (int i = 0; i < 4; i++) begin
      m = 1'($urandom);
      run2(8'($urandom), 8'($urandom), m, m ? 21 : 11, 0, "b2b");
    end
    run2(8'd0, 8'd0, 1'b1, 21, 0, "b2b_zero");
  endtask

  task automatic test_stall();
    run2(8'd10, 8'd20, 1'b0, 11, 50, "stall");
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (soc === 1'b1) begin ok = 1; break; end
      @(negedge clock);
    end
    eoc = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (soc === 1'b0) break;
    end
    x = {8'd9, 8'd9}; mode = 1'b0;
    eoc = 2'b11;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (!ok || dav_ !== 1'b1 || soc !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_outputs dav_=%b soc=%b exp dav_=1 soc=0", dav_, soc);
    end
    checks++;
    if (q !== 18'd0) begin
      errors++;
      $display("FAIL midcalc_q got=%0d exp=0", q);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (soc !== 1'b1) begin
      errors++;
      $display("FAIL midcalc_soc got=%b exp=1", soc);
    end
    run2(8'd2, 8'd3, 1'b0, 11, 0, "after_reset");
  endtask

  task automatic test_skew();
    bit          ok;
    int          cnt;
    logic [31:0] e;

    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (soc4 === 1'b1) begin ok = 1; break; end
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL skew_soc_rise got=%b exp=1", soc4);
    end

    eoc4 = 4'b1000;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (soc4 !== 1'b1) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL skew_soc_hold got=%b exp=1", soc4);
    end
    eoc4 = 4'b0000;
    @(negedge clock);
    checks++;
    if (soc4 !== 1'b0) begin
      errors++;
      $display("FAIL skew_soc_fall got=%b exp=0", soc4);
    end

    x4 = '0; mode4 = 1'b1;
    eoc4 = 4'b0111;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dav4_ !== 1'b1) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL skew_early_dav got=%b exp=1", dav4_);
    end

    x4 = {4{12'hFFF}}; mode4 = 1'b0;
    exp_q.push_back(32'd268304400);
    eoc4 = 4'hF;
    cnt = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cnt++;
      x4 = '0; mode4 = 1'b1;
      if (dav4_ === 1'b0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || (cnt - 1) != 16) begin
      errors++;
      $display("FAIL skew_latency got=%0d exp=16", cnt - 1);
    end
    checks++;
    e = exp_q.pop_front();
    if (32'(q4) !== e) begin
      errors++;
      $display("FAIL skew_q got=%0d exp=%0d", q4, e);
    end

    rfd4 = 1'b0;
    @(negedge clock);
    checks++;
    if (dav4_ !== 1'b1) begin
      errors++;
      $display("FAIL skew_dav_rise got=%b exp=1", dav4_);
    end
    rfd4 = 1'b1;
    @(negedge clock);
    checks++;
    if (soc4 !== 1'b1) begin
      errors++;
      $display("FAIL skew_soc_restart got=%b exp=1", soc4);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_stall();
    test_reset_mid_calc();
    test_skew();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
